rto_write_arbiter: RTL and testbench

RTO_WRITE_ARBITER -- requirements
Module: rto_write_arbiter

---
 rtl/rto_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 35 +++
 rtl/rto_write_arbiter.sv | 90 +++++++++
 tb/tb_rto_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rto_arb_pkg.sv
// Shared types and widths for the RTO write arbiter.
//   NUM_REQ requesters, each offering DATA_W-bit entries ({timestamp, payload}).
package rto_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TS_W    = 64;
  localparam int unsigned PAY_W   = DATA_W - TS_W;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned WCNT_W  = 32;
  localparam int unsigned DCNT_W  = 16;

  typedef logic [IDX_W-1:0] req_idx_t;

  // One queued RTO entry as carried on req_data / fifo_din.
  typedef struct packed {
    logic [TS_W-1:0]  timestamp;
    logic [PAY_W-1:0] payload;
  } rto_entry_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
//   req_valid  : per-requester valid
//   last_grant : most recently granted index; search starts one above it
//   grant_oh   : one-hot winner (zero when nothing is valid)
//   grant_idx  : binary index of the winner
//   grant_any  : any requester valid
module rr_priority_picker
  import rto_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  req_idx_t           last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output req_idx_t           grant_idx,
  output logic               grant_any
);

  req_idx_t cand;

  // Walk the requesters cyclically from last_grant+1; first valid one wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = req_idx_t'(32'(last_grant) + k);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rto_write_arbiter.sv
// Round-robin arbiter feeding the RTO core FIFO through a one-entry holding
// register. A grant loads the hold register; the entry is written on the next
// cycle that the FIFO is not full, and can be discarded by flush.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop pending entry, block grants this cycle
//   enable         : allow new grants
//   req_valid/data : 4 requesters, 128-bit entries packed per requester
//   req_ready      : one-hot accept
//   full           : downstream prog_full
//   write/fifo_din : write strobe and entry to the RTO core
//   last_grant     : most recently granted requester
//   write_count    : entries written (wrapping)
//   drop_count     : entries flushed (saturating)
module rto_write_arbiter
  import rto_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        full,
  output logic                        write,
  output logic [DATA_W-1:0]           fifo_din,
  output req_idx_t                    last_grant,
  output logic [WCNT_W-1:0]           write_count,
  output logic [DCNT_W-1:0]           drop_count
);

  rto_entry_t         req_entry [NUM_REQ];
  rto_entry_t         hold_data;
  logic               hold_valid;
  logic               can_grant;
  logic               grant_fire;
  logic [NUM_REQ-1:0] pick_oh;
  req_idx_t           pick_idx;
  logic               pick_any;

  // Unpack the flat request bus into per-requester entries.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_entry[i] = rto_entry_t'(req_data[i*DATA_W +: DATA_W]);
  end

  rr_priority_picker u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  // Write and accept decisions; reset masks both so nothing leaks during reset.
  always_comb begin
    write      = hold_valid && !full && !flush && !reset;
    can_grant  = enable && !flush && !full && (!hold_valid || write) && !reset;
    grant_fire = can_grant && pick_any;
    req_ready  = can_grant ? pick_oh : '0;
    fifo_din   = DATA_W'(hold_data);
  end

  // Hold register, grant pointer and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      last_grant  <= req_idx_t'(NUM_REQ - 1);
      write_count <= '0;
      drop_count  <= '0;
    end else begin
      if (grant_fire) begin
        hold_data  <= req_entry[pick_idx];
        hold_valid <= 1'b1;
        last_grant <= pick_idx;
      end else if (write) begin
        hold_valid <= 1'b0;
      end else if (flush && hold_valid) begin
        hold_valid <= 1'b0;
        if (drop_count != '1) begin
          drop_count <= drop_count + DCNT_W'(1);
        end
      end
      if (write) begin
        write_count <= write_count + WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rto_write_arbiter.sv
// Self-checking bench: directed scenarios plus a random run, all compared
// against a behavioural model of the arbiter's rules.
module tb_rto_write_arbiter;
  import rto_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset, flush, enable, full;
  logic [3:0]   req_valid;
  logic [511:0] req_data;
  logic [3:0]   req_ready;
  logic         write;
  logic [127:0] fifo_din;
  logic [1:0]   last_grant;
  logic [31:0]  write_count;
  logic [15:0]  drop_count;

  rto_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .write       (write),
    .fifo_din    (fifo_din),
    .last_grant  (last_grant),
    .write_count (write_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit           m_hv;
  logic [127:0] m_hd;
  int           m_lg;
  longint       m_wc;
  int           m_dc;

  // Scoreboard
  int  sb_grants, sb_writes, sb_drops, sb_wf;
  int  wait_cnt [4];
  int  max_wait;
  int  g_last;      // winner in the most recent step, -1 if none
  bit  w_last;      // write seen in the most recent step

  function automatic int rr_pick(input logic [3:0] v, input int lg);
    for (int k = 1; k <= 4; k++) begin
      if (v[(lg + k) % 4]) return (lg + k) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check against the model, advance the model.
  task automatic step(input logic r, input logic fl, input logic en,
                      input logic fu, input logic [3:0] v);
    bit           ew, cg;
    int           g;
    logic [3:0]   er;
    logic [127:0] d;
    reset = r; flush = fl; enable = en; full = fu; req_valid = v;
    for (int i = 0; i < 16; i++) req_data[i*32 +: 32] = $urandom;
    @(negedge clk);
    ew = !r && m_hv && !fu && !fl;
    cg = !r && en && !fl && !fu && (!m_hv || ew);
    g  = cg ? rr_pick(v, m_lg) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready",   128'(req_ready),   128'(er));
    check("write",       128'(write),       128'(ew));
    check("fifo_din",    fifo_din,          m_hd);
    check("last_grant",  128'(last_grant),  128'(m_lg));
    check("write_count", 128'(write_count), 128'(m_wc[31:0]));
    check("drop_count",  128'(drop_count),  128'(m_dc));
    if (write && full) sb_wf++;
    if (!r && g >= 0) begin
      for (int i = 0; i < 4; i++) begin
        if (i == g || !v[i]) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) if (!v[i]) wait_cnt[i] = 0;
    g_last = g;
    w_last = ew;
    d = (g >= 0) ? req_data[g*128 +: 128] : '0;
    @(posedge clk);
    if (r) begin
      m_hv = 0; m_hd = '0; m_lg = 3; m_wc = 0; m_dc = 0;
    end else begin
      if (g >= 0) begin
        m_hd = d; m_hv = 1; m_lg = g; sb_grants++;
      end else if (ew) begin
        m_hv = 0;
      end else if (fl && m_hv) begin
        m_hv = 0; sb_drops++;
        if (m_dc < 16'hFFFF) m_dc++;
      end
      if (ew) begin
        m_wc = (m_wc + 1) % 64'h1_0000_0000; sb_writes++;
      end
    end
    #1;
  endtask

  logic [127:0] saved;
  int           lg_before, wc_before;

  initial begin
    reset = 1; flush = 0; enable = 1; full = 0; req_valid = '0; req_data = '0;
    m_hv = 0; m_hd = '0; m_lg = 3; m_wc = 0; m_dc = 0;
    max_wait = 0; sb_wf = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    @(posedge clk); #1;

    // Reset state, with everything requesting and a flush attempt
    step(1, 1, 1, 0, 4'b1111);
    check("rst_lg3", 128'(last_grant), 128'd3);

    // All requesting: 0,1,2,3,0 with writes from the second cycle onward
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 4'b1111);
      check("rr_order", 128'(g_last), 128'(i % 4));
      check("rr_write", 128'(w_last), 128'(i != 0));
    end
    step(0, 0, 1, 0, 4'b0000);

    // Requester 2 only, full for 5 cycles after its grant
    step(0, 0, 1, 0, 4'b0100);
    check("r2_grant", 128'(g_last), 128'd2);
    saved = m_hd;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 4'b0100);
      check("full_nowr", 128'(w_last), 128'd0);
      check("full_nogr", 128'(g_last), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    end
    step(0, 0, 1, 0, 4'b0000);
    check("full_pulse", 128'(w_last), 128'd1);
    check("full_data", fifo_din, saved);
    step(0, 0, 1, 0, 4'b0000);
    check("full_once", 128'(w_last), 128'd0);

    // Hold loaded, full high, then flush: dropped, never written
    step(1, 0, 1, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0001);
    lg_before = m_lg;
    wc_before = write_count;
    step(0, 0, 1, 1, 4'b0000);
    step(0, 1, 1, 1, 4'b0000);
    check("flush_nowr", 128'(w_last), 128'd0);
    step(0, 0, 1, 0, 4'b0000);
    check("drop_1", 128'(drop_count), 128'd1);
    check("flush_lg", 128'(last_grant), 128'(lg_before));
    check("flush_wc", 128'(write_count), 128'(wc_before));
    check("flush_gone", 128'(w_last), 128'd0);

    // enable low drains the pending entry without granting
    step(0, 0, 1, 0, 4'b0010);
    wc_before = write_count;
    step(0, 0, 0, 0, 4'b1111);
    check("en0_write", 128'(w_last), 128'd1);
    step(0, 0, 0, 0, 4'b1111);
    check("en0_ready", 128'(req_ready), 128'd0);
    check("en0_wc", 128'(write_count), 128'(wc_before + 1));

    // Reset mid-stream with hold valid and flush together
    step(0, 0, 1, 0, 4'b1111);
    step(0, 0, 1, 1, 4'b1111);
    step(1, 1, 1, 1, 4'b1111);
    step(0, 0, 0, 1, 4'b1111);
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_write", 128'(write), 128'd0);
    check("rst_din", fifo_din, 128'd0);
    check("rst_lg", 128'(last_grant), 128'd3);
    check("rst_dc", 128'(drop_count), 128'd0);
    check("rst_wc", 128'(write_count), 128'd0);

    // Random traffic
    step(1, 0, 1, 0, 4'b0000);
    sb_grants = 0; sb_writes = 0; sb_drops = 0; sb_wf = 0; max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 3), 4'($urandom));
    end
    check("sb_write_full", 128'(sb_wf), 128'd0);
    check("sb_conserve", 128'(sb_writes + sb_drops + int'(m_hv)), 128'(sb_grants));
    check("sb_starve", 128'(max_wait <= 3), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
